// File: rtl/sha512_block_padder.sv
// sha512_block_padder
//   Collects 64-bit big-endian message words into 1024-bit SHA-512 blocks and
//   applies the standard padding: a 0x80 marker after the last message byte,
//   zero fill, and the 128-bit message bit length in the last 16 bytes. When
//   the marker or the length does not fit, a second all-padding block follows.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       message word handshake
//   in_data                 message word, byte 0 in bits [63:56]
//   in_last, in_bytes       final word marker and its valid byte count (0..8)
//   blk_valid/blk_ready     block handshake towards the compressor
//   blk_data                block, word 0 in [1023:960], word 15 in [63:0]
//   blk_first, blk_last     first block of a message / final block with length
module sha512_block_padder #(
  parameter int LEN_W = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_data,
  input  logic            in_last,
  input  logic [3:0]      in_bytes,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic [1023:0]   blk_data,
  output logic            blk_first,
  output logic            blk_last
);

  localparam logic [1:0] FILL       = 2'd0;
  localparam logic [1:0] SEND       = 2'd1;
  localparam logic [1:0] SEND_EXTRA = 2'd2;

  logic [1:0]       state;
  logic [3:0]       wcnt;
  logic [LEN_W-1:0] bit_len;
  // extra_pending: the current SEND block must be followed by a length block.
  // extra_mark: the 0x80 marker did not fit either, so it leads the extra block.
  logic             extra_pending;
  logic             extra_mark;

  logic             xfer;
  logic             blk_hs;
  logic [3:0]       nb;
  logic [63:0]      masked;
  logic [7:0]       pad_pos;
  logic [LEN_W-1:0] len_next;
  logic [1023:0]    merged;
  logic [1023:0]    padded;
  logic [1023:0]    extra_blk;

  assign in_ready  = (state == FILL);
  assign blk_valid = (state == SEND) || (state == SEND_EXTRA);
  assign xfer      = in_valid && in_ready;
  assign blk_hs    = blk_valid && blk_ready;

  // Byte count clamp, tail masking and the running length for this transfer.
  always_comb begin
    nb = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    masked = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nb)) masked[63-8*i -: 8] = in_data[63-8*i -: 8];
    end
    pad_pos = 8'({wcnt, 3'b000}) + 8'(nb);
    if (in_last) len_next = bit_len + (LEN_W'(nb) << 3);
    else         len_next = bit_len + LEN_W'(64);
  end

  // Candidate block contents: the word merged in at wcnt, the padded version
  // for a final word, and the trailing length-only block. Bytes past the
  // marker are cleared explicitly because blk_data still holds the previous
  // block's words above wcnt.
  always_comb begin
    merged = blk_data;
    merged[1023-64*int'(wcnt) -: 64] = in_last ? masked : in_data;
    padded = '0;
    for (int b = 0; b < 128; b++) begin
      if (b < int'(pad_pos))       padded[1023-8*b -: 8] = merged[1023-8*b -: 8];
      else if (b == int'(pad_pos)) padded[1023-8*b -: 8] = 8'h80;
    end
    if (pad_pos <= 8'd111) padded[127:0] = 128'(len_next);
    extra_blk = '0;
    extra_blk[1023:1016] = extra_mark ? 8'h80 : 8'h00;
    extra_blk[127:0] = 128'(bit_len);
  end

  // Main control: word collection in FILL, block hand-off in SEND/SEND_EXTRA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      wcnt          <= '0;
      bit_len       <= '0;
      blk_first     <= 1'b1;
      blk_last      <= 1'b0;
      blk_data      <= '0;
      extra_pending <= 1'b0;
      extra_mark    <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (xfer) begin
            if (in_last) begin
              blk_data      <= padded;
              bit_len       <= len_next;
              blk_last      <= (pad_pos <= 8'd111);
              extra_pending <= (pad_pos >= 8'd112);
              extra_mark    <= (pad_pos == 8'd128);
              state         <= SEND;
            end else begin
              blk_data <= merged;
              bit_len  <= len_next;
              wcnt     <= wcnt + 4'd1;
              if (wcnt == 4'd15) begin
                blk_last      <= 1'b0;
                extra_pending <= 1'b0;
                state         <= SEND;
              end
            end
          end
        end
        SEND: begin
          if (blk_hs) begin
            wcnt <= '0;
            if (extra_pending) begin
              blk_data      <= extra_blk;
              blk_last      <= 1'b1;
              blk_first     <= 1'b0;
              extra_pending <= 1'b0;
              state         <= SEND_EXTRA;
            end else if (blk_last) begin
              bit_len   <= '0;
              blk_first <= 1'b1;
              blk_last  <= 1'b0;
              state     <= FILL;
            end else begin
              blk_first <= 1'b0;
              state     <= FILL;
            end
          end
        end
        SEND_EXTRA: begin
          if (blk_hs) begin
            wcnt       <= '0;
            bit_len    <= '0;
            blk_first  <= 1'b1;
            blk_last   <= 1'b0;
            extra_mark <= 1'b0;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha512_block_padder.sv
// tb_sha512_block_padder
//   Directed bench for sha512_block_padder: single-word messages from a vector
//   table, then multi-block, stall and mid-message reset sequences.
module tb_sha512_block_padder;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic [3:0]    in_bytes = '0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [1023:0] blk_data;
  logic          blk_first;
  logic          blk_last;

  int checkCount = 0;
  int errorCount = 0;

  logic [1023:0] capBlk;
  logic          capFirst;
  logic          capLast;
  logic [63:0]   orAcc;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  bytes;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] w15;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  sha512_block_padder #(.LEN_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  function automatic logic [63:0] wordOf(input logic [1023:0] b, input int i);
    return b[1023-64*i -: 64];
  endfunction

  function automatic logic [63:0] pat(input int i);
    return 64'hA5C3_0000_1000_0000 | 64'(i + 1);
  endfunction

  // One comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one word and hold it until it is accepted (bounded).
  task automatic applyStimulus(input logic [63:0] d, input logic l, input logic [3:0] b);
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0;
  endtask

  // Wait for a block (bounded), capture it and complete the handshake.
  task automatic takeBlock();
    int guard = 0;
    while (!blk_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!blk_valid) checkOutput("blk_valid_timeout", 64'(blk_valid), 64'd1);
    capBlk = blk_data; capFirst = blk_first; capLast = blk_last;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic checkMidZero(input string name, input int lo, input int hi);
    orAcc = '0;
    for (int i = lo; i <= hi; i++) orAcc = orAcc | wordOf(capBlk, i);
    checkOutput(name, orAcc, 64'd0);
  endtask

  // One-word message from the table, expecting a single final block.
  task automatic runSingle(input vec_t v, input string tag);
    applyStimulus(v.data, 1'b1, v.bytes);
    checkOutput({tag, "_latency"}, 64'(blk_valid), 64'd1);
    takeBlock();
    checkOutput({tag, "_w0"}, wordOf(capBlk, 0), v.w0);
    checkOutput({tag, "_w1"}, wordOf(capBlk, 1), v.w1);
    checkOutput({tag, "_w15"}, wordOf(capBlk, 15), v.w15);
    checkMidZero({tag, "_w2_14"}, 2, 14);
    checkOutput({tag, "_first"}, 64'(capFirst), 64'd1);
    checkOutput({tag, "_last"}, 64'(capLast), 64'd1);
    checkOutput({tag, "_done"}, 64'(blk_valid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h0123456789ABCDEF, 4'd8,  64'h0123456789ABCDEF, 64'h8000000000000000, 64'h40};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 4'd0,  64'h8000000000000000, 64'h0, 64'h0};
    vecs[2] = '{64'h6162630000000000, 4'd3,  64'h6162638000000000, 64'h0, 64'h18};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 4'd1,  64'hFF80000000000000, 64'h0, 64'h8};
    vecs[4] = '{64'h0123456789ABCDEF, 4'd5,  64'h0123456789800000, 64'h0, 64'h28};
    vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 4'd12, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h40};
    vecs[6] = '{64'hAABBCCDDEEFF1122, 4'd7,  64'hAABBCCDDEEFF1180, 64'h0, 64'h38};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_blk_valid", 64'(blk_valid), 64'd0);
    checkOutput("rst_blk_data", 64'(|blk_data), 64'd0);
    checkOutput("rst_blk_last", 64'(blk_last), 64'd0);
    checkOutput("rst_blk_first", 64'(blk_first), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] single-word table");
    for (int k = 0; k < 7; k++) runSingle(vecs[k], $sformatf("vec%0d", k));

    $display("[TB] 112-byte message");
    for (int i = 0; i < 13; i++) applyStimulus(pat(i), 1'b0, 4'd0);
    applyStimulus(pat(13), 1'b1, 4'd8);
    checkOutput("m112_latency", 64'(blk_valid), 64'd1);
    takeBlock();
    orAcc = '0;
    for (int i = 0; i < 14; i++) orAcc = orAcc | (wordOf(capBlk, i) ^ pat(i));
    checkOutput("m112_b1_data", orAcc, 64'd0);
    checkOutput("m112_b1_w14", wordOf(capBlk, 14), 64'h8000000000000000);
    checkOutput("m112_b1_w15", wordOf(capBlk, 15), 64'h0);
    checkOutput("m112_b1_first", 64'(capFirst), 64'd1);
    checkOutput("m112_b1_last", 64'(capLast), 64'd0);
    checkOutput("m112_b2_latency", 64'(blk_valid), 64'd1);
    takeBlock();
    checkMidZero("m112_b2_w0_14", 0, 14);
    checkOutput("m112_b2_w15", wordOf(capBlk, 15), 64'h380);
    checkOutput("m112_b2_first", 64'(capFirst), 64'd0);
    checkOutput("m112_b2_last", 64'(capLast), 64'd1);

    $display("[TB] 128-byte message");
    for (int i = 0; i < 15; i++) applyStimulus(pat(i), 1'b0, 4'd0);
    applyStimulus(pat(15), 1'b1, 4'd8);
    takeBlock();
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("m128_b1_w%0d", i), wordOf(capBlk, i), pat(i));
    checkOutput("m128_b1_first", 64'(capFirst), 64'd1);
    checkOutput("m128_b1_last", 64'(capLast), 64'd0);
    checkOutput("m128_b2_latency", 64'(blk_valid), 64'd1);
    takeBlock();
    checkOutput("m128_b2_w0", wordOf(capBlk, 0), 64'h8000000000000000);
    checkMidZero("m128_b2_w1_14", 1, 14);
    checkOutput("m128_b2_w15", wordOf(capBlk, 15), 64'h400);
    checkOutput("m128_b2_first", 64'(capFirst), 64'd0);
    checkOutput("m128_b2_last", 64'(capLast), 64'd1);

    $display("[TB] 131-byte message across a non-final block");
    for (int i = 0; i < 16; i++) applyStimulus(pat(i), 1'b0, 4'd0);
    checkOutput("m131_b1_latency", 64'(blk_valid), 64'd1);
    takeBlock();
    checkOutput("m131_b1_w15", wordOf(capBlk, 15), pat(15));
    checkOutput("m131_b1_first", 64'(capFirst), 64'd1);
    checkOutput("m131_b1_last", 64'(capLast), 64'd0);
    checkOutput("m131_refill", 64'(in_ready), 64'd1);
    applyStimulus(64'h6162630000000000, 1'b1, 4'd3);
    takeBlock();
    checkOutput("m131_b2_w0", wordOf(capBlk, 0), 64'h6162638000000000);
    checkMidZero("m131_b2_w1_14", 1, 14);
    checkOutput("m131_b2_w15", wordOf(capBlk, 15), 64'h418);
    checkOutput("m131_b2_first", 64'(capFirst), 64'd0);
    checkOutput("m131_b2_last", 64'(capLast), 64'd1);

    $display("[TB] back-pressure stall");
    applyStimulus(64'h6162630000000000, 1'b1, 4'd3);
    capBlk = blk_data; capFirst = blk_first; capLast = blk_last;
    in_valid = 1'b1; in_data = 64'hDEADBEEFDEADBEEF; in_last = 1'b1; in_bytes = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_data", c), 64'(blk_data != capBlk), 64'd0);
      checkOutput($sformatf("stall%0d_flags", c), {61'd0, blk_valid, blk_first, blk_last}, {61'd0, 1'b1, capFirst, capLast});
      checkOutput($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0;
    checkOutput("stall_w0", wordOf(capBlk, 0), 64'h6162638000000000);
    checkOutput("stall_w15", wordOf(capBlk, 15), 64'h18);
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    begin
      int extra = 0;
      for (int c = 0; c < 4; c++) begin
        if (blk_valid) extra++;
        @(posedge clk); #1;
      end
      checkOutput("stall_one_transfer", 64'(extra), 64'd0);
    end
    runSingle(vecs[2], "post_stall");

    $display("[TB] reset mid-message");
    for (int i = 0; i < 7; i++) applyStimulus(pat(i), 1'b0, 4'd0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (blk_valid) seen++;
        @(posedge clk); #1;
      end
      checkOutput("midrst_no_block", 64'(seen), 64'd0);
    end
    runSingle(vecs[2], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/sha512_block_padder.md
SHA512_BLOCK_PADDER -- requirements
Module: sha512_block_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 128, message bit-length counter width (SHA-512 length field).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports, as name, direction, width, meaning:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, message word offered.
- in_ready, output, 1, padder accepts the word.
- in_data, input, 64, message word, big-endian, byte 0 in bits [63:56].
- in_last, input, 1, final word of the message.
- in_bytes, input, 4, valid bytes in the final word (0..8); ignored unless in_last.
- blk_valid, output, 1, padded 1024-bit block offered.
- blk_ready, input, 1, compressor accepts the block.
- blk_data, output, 1024, block; word 0 in bits [1023:960], word 15 in [63:0].
- blk_first, output, 1, block is the first of its message.
- blk_last, output, 1, block is the final block and carries the length.

Function
REQ-004 SHALL implement FSM states FILL, SEND and SEND_EXTRA.
REQ-005 SHALL assert in_ready only in FILL, and blk_valid only in SEND or SEND_EXTRA.
REQ-006 SHALL transfer a word on in_valid && in_ready, storing it at word index wcnt (0..15).
REQ-007 SHALL, on a non-last transfer, increment wcnt and add 64 to the bit length; the wcnt==15 transfer SHALL move to SEND with blk_last=0.
REQ-008 SHALL, on an in_last transfer, zero the bytes at and beyond in_bytes, treat in_bytes>8 as 8, and add 8*in_bytes to the bit length.
REQ-009 SHALL compute pad byte offset p = 8*wcnt + in_bytes (0..128) on an in_last transfer.
REQ-010 SHALL, if p<=111, place 0x80 at byte p, zeros after it, and the LEN_W-bit length (zero-extended to 128 bits) in bytes 112..127, then move to SEND with blk_last=1.
REQ-011 SHALL, if 112<=p<=127, place 0x80 at byte p and zeros after it, then move to SEND with blk_last=0.
REQ-012 SHALL, if p==128, leave the block data unchanged and move to SEND with blk_last=0.
REQ-013 SHALL, in the p>=112 cases, follow the SEND handshake with SEND_EXTRA: an all-zero block, 0x80 at byte 0 only when p==128, length in bytes 112..127, blk_last=1.
REQ-014 SHALL make blk_valid rise the cycle after the triggering input transfer or the preceding block handshake.
REQ-015 SHALL hold blk_data, blk_first and blk_last stable while blk_valid && !blk_ready.
REQ-016 SHALL, on the handshake of a non-final block, return to FILL with wcnt=0.
REQ-017 SHALL, on the blk_last handshake, return to FILL with wcnt=0, bit length 0 and blk_first re-armed.
REQ-018 SHALL set blk_first=1 only on the first block emitted after reset or after a blk_last handshake.
REQ-019 SHALL accumulate the bit length modulo 2^LEN_W; overflow SHALL wrap silently.
REQ-020 SHALL treat in_last with in_bytes=0 at wcnt=0 as the empty message.
REQ-021 SHALL ignore in_valid outside FILL; no word is lost or duplicated.

Reset
REQ-022 SHALL, while rst_n=0, force state FILL, wcnt=0, bit length 0, blk_first armed, blk_valid=0, blk_last=0 and blk_data=0.
REQ-023 SHALL make in_ready=1 in the first cycle after rst_n deasserts.
REQ-024 SHALL discard any partial message or pending block on reset mid-operation, with no block emitted afterwards.

Verification
REQ-025 Empty message: in_last, in_bytes=0 -> one block, word0=64'h8000000000000000, all other words 0, blk_first=blk_last=1.
REQ-026 "abc": in_data=64'h6162630000000000, in_bytes=3, in_last -> word0=64'h6162638000000000, word15=64'h18, words 1..14 zero, blk_first=blk_last=1.
REQ-027 112 bytes (13 full words, then a last word with in_bytes=8) -> block1: word14=64'h8000000000000000, word15=0, blk_last=0; block2: words 0..14 zero, word15=64'h380, blk_first=0, blk_last=1.
REQ-028 128 bytes (16 full words, the 16th with in_last, in_bytes=8) -> block1 = raw data, blk_last=0; block2: word0=64'h8000000000000000, word15=64'h400, blk_last=1.
REQ-029 blk_ready held low 5 cycles in SEND -> blk_data, blk_first, blk_last unchanged; in_ready=0 throughout; exactly one transfer when blk_ready rises.
REQ-030 rst_n pulsed after 7 words -> no block emitted; a subsequent "abc" message yields the REQ-026 block with blk_first=1.
